// File: rtl/pe_ctrl_pkg.sv
// Shared types and packet-layout helpers for the PE controller.
package pe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_F,
        LOAD_I,
        START,
        COLLECT,
        SEND,
        WAIT_DONE
    } state_t;

    localparam logic [1:0] PKT_TYPE_IN  = 2'b01;
    localparam logic [1:0] PKT_TYPE_OUT = 2'b10;

    // Index width that stays legal for a depth of one.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // The filter field sits at the LSB end; the ifmap field starts right above it.
    function automatic int ifmap_lsb(input int filt_w, input int depth_f);
        return filt_w * depth_f;
    endfunction

    function automatic int addr_lsb(input int filt_w, input int depth_f,
                                    input int ifmap_w, input int depth_i);
        return filt_w * depth_f + ifmap_w * depth_i;
    endfunction

    function automatic int type_lsb(input int addr_w, input int filt_w, input int depth_f,
                                    input int ifmap_w, input int depth_i);
        return addr_lsb(filt_w, depth_f, ifmap_w, depth_i) + addr_w;
    endfunction

    function automatic int pkt_width(input int addr_w, input int filt_w, input int depth_f,
                                     input int ifmap_w, input int depth_i);
        return type_lsb(addr_w, filt_w, depth_f, ifmap_w, depth_i) + 2;
    endfunction

endpackage

// File: rtl/pe_psum_buf.sv
// Per-column partial-sum accumulator storage, cleared while reset is held.
module pe_psum_buf #(
    parameter int NUM_OUT = 3,
    parameter int PSUM_W  = 8,
    parameter int AW      = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [PSUM_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [PSUM_W-1:0] rdata
);

    logic [PSUM_W-1:0] mem [NUM_OUT];

    // Clear every entry on reset, otherwise accept one write per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < NUM_OUT)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < NUM_OUT) ? mem[raddr] : '0;

endmodule

// File: rtl/pe_ctrl_acc.sv
// PE controller: loads filter/ifmap memories from a packet, runs the MAC,
// accumulates psums across passes and emits one packet per output column.
module pe_ctrl_acc
    import pe_ctrl_pkg::*;
#(
    parameter int         ADDR_W   = 8,
    parameter int         FILT_W   = 8,
    parameter int         IFMAP_W  = 1,
    parameter int         DEPTH_F  = 3,
    parameter int         DEPTH_I  = 5,
    parameter int         PSUM_W   = 8,
    parameter int         NUM_PASS = 1,
    parameter logic [1:0] OUT_ROW  = 2'b01,
    localparam int PKT_W   = pkt_width(ADDR_W, FILT_W, DEPTH_F, IFMAP_W, DEPTH_I),
    localparam int NUM_OUT = DEPTH_I - DEPTH_F + 1,
    localparam int FA_W    = idx_width(DEPTH_F),
    localparam int IA_W    = idx_width(DEPTH_I)
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_in_valid,
    output logic               pkt_in_ready,
    input  logic [PKT_W-1:0]   pkt_in_data,
    output logic               pkt_out_valid,
    input  logic               pkt_out_ready,
    output logic [PKT_W-1:0]   pkt_out_data,
    output logic               filt_we,
    output logic [FA_W-1:0]    filt_waddr,
    output logic [FILT_W-1:0]  filt_wdata,
    output logic               ifmap_we,
    output logic [IA_W-1:0]    ifmap_waddr,
    output logic [IFMAP_W-1:0] ifmap_wdata,
    output logic               mac_start,
    output logic [PSUM_W-1:0]  psum_in,
    input  logic               psum_valid,
    output logic               psum_ready,
    input  logic [PSUM_W-1:0]  psum_data,
    input  logic               mac_done,
    output logic               busy
);

    localparam int FILT_F_W = FILT_W * DEPTH_F;
    localparam int IF_F_W   = IFMAP_W * DEPTH_I;
    localparam int IF_LSB   = ifmap_lsb(FILT_W, DEPTH_F);
    localparam int ADDR_LSB = addr_lsb(FILT_W, DEPTH_F, IFMAP_W, DEPTH_I);
    localparam int TYPE_LSB = type_lsb(ADDR_W, FILT_W, DEPTH_F, IFMAP_W, DEPTH_I);
    localparam int CW       = idx_width(NUM_OUT);
    localparam int PW       = idx_width(NUM_PASS);
    localparam int LW       = idx_width((DEPTH_F > DEPTH_I) ? DEPTH_F : DEPTH_I);

    state_t             state_q, state_d;
    logic [TYPE_LSB-1:0] pkt_q;
    logic [PKT_W-1:0]   out_q;
    logic [LW-1:0]      idx_q;
    logic [CW-1:0]      col_q;
    logic [PW-1:0]      pass_q;
    logic               buf_we;
    logic [PSUM_W-1:0]  buf_wdata;
    logic [PSUM_W-1:0]  buf_rdata;
    logic [1:0]         col_tag;
    logic               pass_last;
    logic               col_last;
    logic               type_ok;

    assign pass_last = (pass_q == PW'(NUM_PASS - 1));
    assign col_last  = (col_q == CW'(NUM_OUT - 1));
    assign col_tag   = 2'(col_q + 1'b1);
    assign type_ok   = (pkt_in_data[TYPE_LSB +: 2] == PKT_TYPE_IN);
    assign busy      = (state_q != IDLE);

    pe_psum_buf #(
        .NUM_OUT (NUM_OUT),
        .PSUM_W  (PSUM_W),
        .AW      (CW)
    ) u_psum_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we),
        .waddr (col_q),
        .wdata (buf_wdata),
        .raddr (col_q),
        .rdata (buf_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and all handshake / memory-port outputs.
    always_comb begin
        state_d       = state_q;
        pkt_in_ready  = 1'b0;
        pkt_out_valid = 1'b0;
        pkt_out_data  = '0;
        filt_we       = 1'b0;
        filt_waddr    = '0;
        filt_wdata    = '0;
        ifmap_we      = 1'b0;
        ifmap_waddr   = '0;
        ifmap_wdata   = '0;
        mac_start     = 1'b0;
        psum_in       = '0;
        psum_ready    = 1'b0;
        buf_we        = 1'b0;
        buf_wdata     = '0;
        unique case (state_q)
            IDLE: begin
                pkt_in_ready = rst_n;
                if (pkt_in_valid && rst_n && type_ok) begin
                    state_d = LOAD_F;
                end
            end
            LOAD_F: begin
                filt_we    = 1'b1;
                filt_waddr = FA_W'(idx_q);
                filt_wdata = pkt_q[(DEPTH_F - 1 - int'(idx_q)) * FILT_W +: FILT_W];
                if (idx_q == LW'(DEPTH_F - 1)) begin
                    state_d = LOAD_I;
                end
            end
            LOAD_I: begin
                ifmap_we    = 1'b1;
                ifmap_waddr = IA_W'(idx_q);
                ifmap_wdata = pkt_q[IF_LSB + (DEPTH_I - 1 - int'(idx_q)) * IFMAP_W +: IFMAP_W];
                if (idx_q == LW'(DEPTH_I - 1)) begin
                    state_d = START;
                end
            end
            START: begin
                mac_start = 1'b1;
                state_d   = COLLECT;
            end
            COLLECT: begin
                psum_ready = 1'b1;
                psum_in    = buf_rdata;
                if (psum_valid) begin
                    buf_we = 1'b1;
                    if (pass_last) begin
                        buf_wdata = '0;
                        state_d   = SEND;
                    end else begin
                        buf_wdata = psum_data;
                        state_d   = col_last ? WAIT_DONE : COLLECT;
                    end
                end
            end
            SEND: begin
                pkt_out_valid = 1'b1;
                pkt_out_data  = out_q;
                if (pkt_out_ready) begin
                    state_d = col_last ? WAIT_DONE : COLLECT;
                end
            end
            WAIT_DONE: begin
                if (mac_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: latched packet, load index, column, pass count, output packet.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_q  <= '0;
            out_q  <= '0;
            idx_q  <= '0;
            col_q  <= '0;
            pass_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (pkt_in_valid) begin
                        pkt_q <= pkt_in_data[TYPE_LSB-1:0];
                    end
                end
                LOAD_F: begin
                    idx_q <= (idx_q == LW'(DEPTH_F - 1)) ? '0 : idx_q + 1'b1;
                end
                LOAD_I: begin
                    idx_q <= idx_q + 1'b1;
                end
                START: begin
                    col_q <= '0;
                end
                COLLECT: begin
                    if (psum_valid) begin
                        if (pass_last) begin
                            out_q <= {PKT_TYPE_OUT, pkt_q[ADDR_LSB +: ADDR_W],
                                      IF_F_W'({OUT_ROW, col_tag}), FILT_F_W'(psum_data)};
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (pkt_out_ready) begin
                        col_q <= col_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (mac_done) begin
                        pass_q <= pass_last ? '0 : pass_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ctrl_acc.sv
// Directed bench for pe_ctrl_acc: one instance with a single pass, one with two passes.
module tb_pe_ctrl_acc;

    localparam logic [38:0] PKT_A   = {2'b01, 8'h10, 5'b11101, 8'h0E, 8'h05, 8'h08};
    localparam logic [38:0] PKT_BAD = {2'b11, 8'h10, 5'b11101, 8'h0E, 8'h05, 8'h08};
    localparam logic [23:0] EXP_F   = 24'h0E0508;
    localparam logic [4:0]  EXP_I   = 5'b11101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        pkt_in_valid = 1'b0;
    logic        pkt_out_ready = 1'b1;
    logic        psum_valid = 1'b0;
    logic        mac_done = 1'b0;
    logic [38:0] pkt_in_data = '0;
    logic [7:0]  psum_data = '0;

    logic [1:0]       pkt_in_ready_d, pkt_out_valid_d, filt_we_d, ifmap_we_d;
    logic [1:0]       mac_start_d, psum_ready_d, busy_d, ifmap_wdata_d;
    logic [1:0][38:0] pkt_out_data_d;
    logic [1:0][1:0]  filt_waddr_d;
    logic [1:0][7:0]  filt_wdata_d;
    logic [1:0][2:0]  ifmap_waddr_d;
    logic [1:0][7:0]  psum_in_d;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Instance 0 accumulates one pass, instance 1 two passes; sel routes the handshakes.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        pe_ctrl_acc #(.NUM_PASS(g + 1)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .pkt_in_valid  (pkt_in_valid && (sel == 1'(g))),
            .pkt_in_ready  (pkt_in_ready_d[g]),
            .pkt_in_data   (pkt_in_data),
            .pkt_out_valid (pkt_out_valid_d[g]),
            .pkt_out_ready (pkt_out_ready),
            .pkt_out_data  (pkt_out_data_d[g]),
            .filt_we       (filt_we_d[g]),
            .filt_waddr    (filt_waddr_d[g]),
            .filt_wdata    (filt_wdata_d[g]),
            .ifmap_we      (ifmap_we_d[g]),
            .ifmap_waddr   (ifmap_waddr_d[g]),
            .ifmap_wdata   (ifmap_wdata_d[g:g]),
            .mac_start     (mac_start_d[g]),
            .psum_in       (psum_in_d[g]),
            .psum_valid    (psum_valid && (sel == 1'(g))),
            .psum_ready    (psum_ready_d[g]),
            .psum_data     (psum_data),
            .mac_done      (mac_done && (sel == 1'(g))),
            .busy          (busy_d[g])
        );
    end

    function automatic logic [38:0] outPkt(input logic [4:0] tag, input logic [7:0] psum);
        return {2'b10, 8'h10, tag, 16'h0000, psum};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at a negedge. Sends one packet and checks the load sequence.
    task automatic applyStimulus(input logic [38:0] pkt, input bit good_type);
        int n;
        bit saw_we, saw_mac, saw_busy;
        pkt_in_data  = pkt;
        pkt_in_valid = 1'b1;
        n = 0;
        while (!pkt_in_ready_d[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready", pkt_in_ready_d[sel], 1);
        @(posedge clk);
        #1 pkt_in_valid = 1'b0;
        if (good_type) begin
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (k <= 3) begin
                    checkOutput($sformatf("filt_we[%0d]", k - 1), filt_we_d[sel], 1);
                    checkOutput($sformatf("filt_waddr[%0d]", k - 1), filt_waddr_d[sel], k - 1);
                    checkOutput($sformatf("filt_wdata[%0d]", k - 1), filt_wdata_d[sel],
                                EXP_F[(3 - k) * 8 +: 8]);
                end else if (k <= 8) begin
                    checkOutput($sformatf("ifmap_we[%0d]", k - 4), ifmap_we_d[sel], 1);
                    checkOutput($sformatf("ifmap_waddr[%0d]", k - 4), ifmap_waddr_d[sel], k - 4);
                    checkOutput($sformatf("ifmap_wdata[%0d]", k - 4), ifmap_wdata_d[sel],
                                EXP_I[8 - k]);
                end
                if (k >= 8) begin
                    checkOutput($sformatf("mac_start@%0d", k), mac_start_d[sel], (k == 9));
                end
            end
        end else begin
            saw_we = 0; saw_mac = 0; saw_busy = 0;
            repeat (12) begin
                @(negedge clk);
                if (filt_we_d[sel] || ifmap_we_d[sel]) saw_we = 1;
                if (mac_start_d[sel]) saw_mac = 1;
                if (busy_d[sel]) saw_busy = 1;
            end
            checkOutput("drop_we", saw_we, 0);
            checkOutput("drop_mac_start", saw_mac, 0);
            checkOutput("drop_busy", saw_busy, 0);
            checkOutput("drop_in_ready", pkt_in_ready_d[sel], 1);
        end
    endtask

    // Entered and left at a negedge. One MAC result, optionally one output packet.
    task automatic collectPsum(input logic [7:0] v, input logic [7:0] exp_in, input bit exp_out,
                               input logic [38:0] exp_pkt, input int stall);
        int n;
        bit stable, held;
        psum_data  = v;
        psum_valid = 1'b1;
        n = 0;
        while (!psum_ready_d[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("psum_ready", psum_ready_d[sel], 1);
        checkOutput("psum_in", psum_in_d[sel], exp_in);
        @(posedge clk);
        #1 psum_valid = 1'b0;
        @(negedge clk);
        checkOutput("out_valid", pkt_out_valid_d[sel], exp_out);
        if (exp_out) begin
            checkOutput("out_data", pkt_out_data_d[sel], exp_pkt);
            if (stall > 0) begin
                pkt_out_ready = 1'b0;
                psum_valid    = 1'b1;
                psum_data     = 8'hEE;
                stable = 1; held = 1;
                repeat (stall) begin
                    @(negedge clk);
                    if (!pkt_out_valid_d[sel] || pkt_out_data_d[sel] !== exp_pkt) stable = 0;
                    if (psum_ready_d[sel]) held = 0;
                end
                checkOutput("stall_out_stable", stable, 1);
                checkOutput("stall_psum_ready_low", held, 1);
                psum_valid    = 1'b0;
                pkt_out_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Entered at a negedge in WAIT_DONE; pulses mac_done and checks the return to IDLE.
    task automatic finishPass();
        checkOutput("busy_wait_done", busy_d[sel], 1);
        mac_done = 1'b1;
        @(posedge clk);
        #1 mac_done = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_done", busy_d[sel], 0);
        checkOutput("idle_in_ready", pkt_in_ready_d[sel], 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", pkt_in_ready_d[0], 0);
        checkOutput("rst_busy", busy_d[0], 0);
        checkOutput("rst_out_valid", pkt_out_valid_d[0], 0);
        checkOutput("rst_out_data", pkt_out_data_d[0], 0);
        checkOutput("rst_psum_ready", psum_ready_d[0], 0);
        checkOutput("rst_mac_start", mac_start_d[0], 0);
        checkOutput("rst_we", {filt_we_d[0], ifmap_we_d[0]}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single pass with a 10-cycle stall on the first output packet.
        sel = 1'b0;
        applyStimulus(PKT_A, 1);
        collectPsum(8'd5, 8'd0, 1, outPkt(5'b00101, 8'h05), 10);
        collectPsum(8'd7, 8'd0, 1, outPkt(5'b00110, 8'h07), 0);
        collectPsum(8'd9, 8'd0, 1, outPkt(5'b00111, 8'h09), 0);
        finishPass();

        // Wrong packet type is dropped.
        applyStimulus(PKT_BAD, 0);

        // Two-pass accumulation, then a fresh first pass must see a cleared buffer.
        sel = 1'b1;
        @(negedge clk);
        applyStimulus(PKT_A, 1);
        collectPsum(8'd3, 8'd0, 0, '0, 0);
        collectPsum(8'd4, 8'd0, 0, '0, 0);
        collectPsum(8'd5, 8'd0, 0, '0, 0);
        finishPass();
        applyStimulus(PKT_A, 1);
        collectPsum(8'd10, 8'd3, 1, outPkt(5'b00101, 8'h0A), 0);
        collectPsum(8'd11, 8'd4, 1, outPkt(5'b00110, 8'h0B), 0);
        collectPsum(8'd12, 8'd5, 1, outPkt(5'b00111, 8'h0C), 0);
        finishPass();
        applyStimulus(PKT_A, 1);
        collectPsum(8'd1, 8'd0, 0, '0, 0);
        collectPsum(8'd2, 8'd0, 0, '0, 0);
        collectPsum(8'd3, 8'd0, 0, '0, 0);
        finishPass();

        // Reset while an output packet is being held by backpressure.
        sel = 1'b0;
        @(negedge clk);
        applyStimulus(PKT_A, 1);
        psum_data  = 8'h33;
        psum_valid = 1'b1;
        @(posedge clk);
        #1 psum_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_out_valid", pkt_out_valid_d[0], 1);
        pkt_out_ready = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", pkt_out_valid_d[0], 0);
        checkOutput("mid_rst_out_data", pkt_out_data_d[0], 0);
        checkOutput("mid_rst_busy", busy_d[0], 0);
        checkOutput("mid_rst_in_ready", pkt_in_ready_d[0], 0);
        checkOutput("mid_rst_psum_ready", psum_ready_d[0], 0);
        rst_n = 1'b1;
        pkt_out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_in_ready", pkt_in_ready_d[0], 1);
        checkOutput("post_rst_out_valid", pkt_out_valid_d[0], 0);
        applyStimulus(PKT_A, 1);
        collectPsum(8'h21, 8'd0, 1, outPkt(5'b00101, 8'h21), 0);
        collectPsum(8'h22, 8'd0, 1, outPkt(5'b00110, 8'h22), 0);
        collectPsum(8'h23, 8'd0, 1, outPkt(5'b00111, 8'h23), 0);
        finishPass();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_ctrl_acc.md
Name: pe_ctrl_acc

Overview:
Clocked, parametrised PE controller for the NoC-based CNN accelerator. It accepts one input packet per pass, unpacks its filter and ifmap fields, and writes them into the PE's filter and ifmap memories. It then starts the MAC datapath and collects one partial sum per output column. Partial sums accumulate across NUM_PASS passes, and one output packet per column is emitted to the router after the final pass.

Parameters:
ADDR_W, 8, router address field width
FILT_W, 8, filter element width
IFMAP_W, 1, ifmap element width
DEPTH_F, 3, filter elements per packet
DEPTH_I, 5, ifmap elements per packet
PSUM_W, 8, partial-sum width (PSUM_W <= FILT_W*DEPTH_F)
NUM_PASS, 1, passes accumulated before output (>=1)
OUT_ROW, 2'b01, output row tag placed in outgoing packets
PKT_W, 2+ADDR_W+IFMAP_W*DEPTH_I+FILT_W*DEPTH_F (39), packet width (derived)
NUM_OUT, DEPTH_I-DEPTH_F+1 (3), psums per pass (derived)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
pkt_in_valid / pkt_in_ready  in / out  1 / 1  input packet handshake
pkt_in_data  in  PKT_W  {type[2], addr[ADDR_W], ifmap[DEPTH_I*IFMAP_W] (element 0 at MSB), filter[DEPTH_F*FILT_W] (element 0 at MSB)}
pkt_out_valid / pkt_out_ready  out / in  1 / 1  output packet handshake
pkt_out_data  out  PKT_W  output packet
filt_we, filt_waddr, filt_wdata  out  1, clog2(DEPTH_F), FILT_W  filter memory write port
ifmap_we, ifmap_waddr, ifmap_wdata  out  1, clog2(DEPTH_I), IFMAP_W  ifmap memory write port
mac_start  out  1  one-cycle start pulse to MAC
psum_in  out  PSUM_W  accumulated value for the column currently being computed
psum_valid / psum_ready  in / out  1 / 1  MAC result handshake
psum_data  in  PSUM_W  MAC result (MAC adds psum_in)
mac_done  in  1  one-cycle pulse when MAC has finished the pass
busy  out  1  high in every state except IDLE

Behaviour:
- Handshakes: a transfer happens on a clk edge where valid&&ready are both high. Once valid is asserted, it and its data stay stable until the transfer.
- Reset (rst_n low at clk edge): state=IDLE; pass_cnt=0; col=0; all acc_buf entries 0. pkt_in_ready=0; pkt_out_valid=0; pkt_out_data=0; all we=0; mac_start=0; psum_ready=0; busy=0. Reset mid-operation aborts immediately; no partial packet is emitted afterwards.
- IDLE: pkt_in_ready=1. On transfer, latch the packet. If type!=2'b01, drop it and stay in IDLE. Otherwise go to LOAD_F.
- LOAD_F: one filter write per cycle, addr 0..DEPTH_F-1, data = filter element addr. Takes DEPTH_F cycles, then LOAD_I.
- LOAD_I: one ifmap write per cycle, addr 0..DEPTH_I-1. Takes DEPTH_I cycles, then START.
- START: mac_start=1 for exactly one cycle; col=0; then COLLECT. Packet-accept to mac_start latency = 1+DEPTH_F+DEPTH_I cycles.
- COLLECT: psum_in = acc_buf[col] (0 on pass 0); psum_ready=1.
  - On transfer with pass_cnt<NUM_PASS-1: acc_buf[col]<=psum_data; col++. After col NUM_OUT-1, go to WAIT_DONE.
  - On transfer with pass_cnt==NUM_PASS-1: acc_buf[col]<=0; build the output packet; go to SEND.
- SEND: pkt_out_valid=1 until accepted. pkt_out_data = {2'b10, latched addr, ifmap field = zero-extended {OUT_ROW, col+1} (2-bit col, wraps for NUM_OUT>3), filter field = zero-extended psum_data}. On accept, col++. Return to COLLECT, or go to WAIT_DONE after the last column. Backpressure holds the FSM in SEND; psum_ready stays 0.
- WAIT_DONE: wait for mac_done.
  - If pass_cnt==NUM_PASS-1: pass_cnt<=0. Otherwise pass_cnt++.
  - Then go to IDLE.
  - A mac_done arriving in any other state is ignored.
- Width rules: psum is stored modulo 2^PSUM_W; the controller adds nothing itself.
- pkt_in_valid while not IDLE: ready stays 0, and the packet is held upstream.

Decomposition:
- Package pe_ctrl_pkg: state enum (IDLE, LOAD_F, LOAD_I, START, COLLECT, SEND, WAIT_DONE), PKT_TYPE_IN=2'b01, PKT_TYPE_OUT=2'b10, and field-offset functions derived from the parameters.
- One sub-module, pe_psum_buf: NUM_OUT x PSUM_W register file with synchronous active-low clear, one read port and one write port.

Test Plan:
- Defaults, packet 01_00010000_11101_00001110_00000101_00001000 -> filter writes [0]=0x0E, [1]=0x05, [2]=0x08; ifmap writes 1,1,1,0,1; mac_start 9 cycles after accept.
- Same packet, psums 5, 7, 9 -> three packets 10_00010000_00101_0x00_0x00_0x05, then ..._00110_..._0x07, then ..._00111_..._0x09; busy drops after mac_done.
- pkt_out_ready held low 10 cycles on the first output -> data stable, psum_ready=0, no second psum consumed; resumes correctly.
- NUM_PASS=2, psums 3,4,5 on pass 1 -> no output. Pass 2 presents psum_in=3,4,5; MAC returns 10,11,12 -> outputs 0x0A, 0x0B, 0x0C; acc_buf=0 afterwards.
- Packet type 2'b11 -> no memory writes, no mac_start, stays IDLE.
- rst_n low during SEND -> next cycle all outputs at reset values, pkt_in_ready=1 in IDLE after release, no stale output.
